// File: rtl/register_file.sv
// 16 x 64-bit register file: one synchronous write port, two combinational read ports
// with write-through bypass. An asynchronous active-low reset clears storage and zeroes reads.
module register_file #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  is_write,
  input  logic [ADDR_WIDTH-1:0] write_port_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_port_address_1,
  output logic [DATA_WIDTH-1:0] read_data_1,
  input  logic [ADDR_WIDTH-1:0] read_port_address_2,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  localparam int NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic                  write_en;

  // Only a clean 1 enables a write; X/Z falls through to no-write.
  assign write_en = (is_write === 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_en) begin
      regs_q[write_port_address] <= write_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  rst_ok,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data,
    input logic [ADDR_WIDTH-1:0] rd_addr,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] value;
    value = '0;
    if (rst_ok) begin
      // Bypass lets a same-cycle reader see the value about to be written.
      if (wr_en && (rd_addr == wr_addr)) begin
        value = wr_data;
      end else begin
        value = stored;
      end
    end
    return value;
  endfunction

  always_comb begin
    read_data_1 = '0;
    read_data_1 = read_port(rst_n, write_en, write_port_address, write_data,
                            read_port_address_1, regs_q[read_port_address_1]);
  end

  always_comb begin
    read_data_2 = '0;
    read_data_2 = read_port(rst_n, write_en, write_port_address, write_data,
                            read_port_address_2, regs_q[read_port_address_2]);
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by random traffic
// checked against an array model of the 16 registers.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_write;
  logic [3:0]  wa;
  logic [63:0] wd;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [63:0] rd1;
  logic [63:0] rd2;

  logic [63:0] model [16];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  register_file dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .is_write            (is_write),
    .write_port_address  (wa),
    .write_data          (wd),
    .read_port_address_1 (ra1),
    .read_data_1         (rd1),
    .read_port_address_2 (ra2),
    .read_data_2         (rd2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] expect_rd(input logic [3:0] ra);
    if (rst_n !== 1'b1) return 64'h0;
    if (is_write === 1'b1 && ra == wa) return wd;
    return model[ra];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, "/rd1"}, rd1, expect_rd(ra1));
    check({tag, "/rd2"}, rd2, expect_rd(ra2));
  endtask

  // One rising edge; the model takes the write the DUT should take, inputs then move #1 later.
  task automatic tick();
    logic        do_wr;
    logic [3:0]  a;
    logic [63:0] d;
    do_wr = (rst_n === 1'b1) && (is_write === 1'b1);
    a = wa;
    d = wd;
    @(posedge clk);
    if (do_wr) model[a] = d;
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [63:0] d);
    is_write = 1'b1;
    wa = a;
    wd = d;
    tick();
    is_write = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    is_write = 1'b0;
    wa = 4'd0;
    wd = 64'h0;
    ra1 = 4'd0;
    ra2 = 4'd0;
    for (int i = 0; i < 16; i++) model[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    clear_model();
    #3;
    check("in_reset_rd1", rd1, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All registers read zero after reset.
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i);
      ra2 = 4'(15 - i);
      #1;
      check($sformatf("reset_rd1_%0d", i), rd1, 64'h0);
      check($sformatf("reset_rd2_%0d", i), rd2, 64'h0);
    end

    // Write 50 to register 6; only register 6 changes.
    write(4'd6, 64'd50);
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i);
      #1;
      check($sformatf("after_w6_r%0d", i), rd1, (i == 6) ? 64'd50 : 64'h0);
    end

    // is_write=0 leaves storage untouched whatever the address/data.
    is_write = 1'b0;
    wa = 4'd6;
    wd = 64'd25;
    tick();
    ra1 = 4'd6;
    #1;
    check("nowrite_r6", rd1, 64'd50);
    wa = 4'd3;
    tick();
    ra1 = 4'd3;
    #1;
    check("nowrite_r3", rd1, 64'd0);

    // Bypass on both ports before the edge, then stored value after.
    is_write = 1'b1;
    wa = 4'd9;
    wd = 64'hFFFF_FFFF_FFFF_FFFF;
    ra1 = 4'd9;
    ra2 = 4'd9;
    #1;
    check("bypass9_rd1", rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("bypass9_rd2", rd2, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    is_write = 1'b0;
    #1;
    check("held9_rd1", rd1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("held9_rd2", rd2, 64'hFFFF_FFFF_FFFF_FFFF);

    // Boundary indices on independent ports.
    write(4'd15, 64'hA5);
    write(4'd0, 64'h5A);
    ra1 = 4'd15;
    ra2 = 4'd0;
    #1;
    check("r15", rd1, 64'hA5);
    check("r0", rd2, 64'h5A);

    // Bypass applies per port.
    is_write = 1'b1;
    wa = 4'd4;
    wd = 64'h1234;
    ra1 = 4'd4;
    ra2 = 4'd15;
    #1;
    check("bypass_p1_only", rd1, 64'h1234);
    check("no_bypass_p2", rd2, 64'hA5);
    is_write = 1'b0;
    #1;
    check("no_bypass_we0", rd1, 64'h0);

    // Back-to-back writes to one address keep the last value.
    write(4'd3, 64'd1);
    write(4'd3, 64'd2);
    ra1 = 4'd3;
    #1;
    check("b2b_r3", rd1, 64'd2);

    // Reset pulse between edges clears at once and disables bypass.
    is_write = 1'b1;
    wa = 4'd15;
    wd = 64'h77;
    ra1 = 4'd15;
    ra2 = 4'd9;
    rst_n = 1'b0;
    clear_model();
    #1;
    check("rst_pulse_bypass_off", rd1, 64'h0);
    check("rst_pulse_r9", rd2, 64'h0);
    is_write = 1'b0;
    #1;
    rst_n = 1'b1;
    ra1 = 4'd6;
    ra2 = 4'd0;
    #1;
    check("after_pulse_r6", rd1, 64'h0);
    check("after_pulse_r0", rd2, 64'h0);
    write(4'd2, 64'd7);
    ra1 = 4'd2;
    #1;
    check("resume_r2", rd1, 64'd7);

    // Reset held across a write edge wins.
    is_write = 1'b1;
    wa = 4'd11;
    wd = 64'hCAFE;
    rst_n = 1'b0;
    clear_model();
    tick();
    rst_n = 1'b1;
    is_write = 1'b0;
    ra1 = 4'd11;
    ra2 = 4'd2;
    #1;
    check("rst_wins_r11", rd1, 64'h0);
    check("rst_wins_r2", rd2, 64'h0);

    // Random traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      is_write = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = {$urandom, $urandom};
      ra1 = 4'($urandom_range(0, 15));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      check_ports($sformatf("rand_pre_%0d", n));
      tick();
      is_write = 1'b0;
      check_ports($sformatf("rand_post_%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
